xsum_rx: RTL and testbench
==========================

XSUM_RX -- requirements
Module: xsum_rx

Interface
REQ-001 SHALL have parameter LOCKCNT, default 64, meaning the number of consecutive good words required in HUNT before a link goes UP.
REQ-002 SHALL have parameter ERRMAX, default 4, meaning the leaky-bucket error level in UP at which a link drops to DOWN.
REQ-003 SHALL have parameter LEAKLEN, default 256, meaning the number of consecutive good words in UP that decrements the bucket by 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as follows (clock and reset first).
- clk  in  1  master clock, all logic posedge
- reset  in  1  synchronous reset, active high
- rxdata  in  48  received words, link k on [16k+15:16k], k=0..2
- rxcharisk  in  6  K flags, link k on [2k+1:2k], bit 2k for the low byte
- rxerr  in  3  per-link disparity or not-in-table error
- xdata  out  48  cleaned sums to the summing logic
- xcomma  out  3  per-link comma/neutral flag (1 = contributes zero)
- linkup  out  3  per-link UP status
- errtot  out  48  per-link 16-bit saturating error totals, link k on [16k+15:16k]
- errclr  in  1  clears all errtot, one clk pulse

Function
REQ-005 SHALL classify each link's word every clk, independently per link:
- COMMA: charisk==2'b01, data==16'h00BC, rxerr==0
- GOOD: charisk==2'b00, rxerr==0
- ERROR: anything else
REQ-006 SHALL run one FSM per link, states DOWN, HUNT and UP, all entered at reset into DOWN.
REQ-007 SHALL move DOWN->HUNT on COMMA; GOOD and ERROR words SHALL hold DOWN.
REQ-008 In HUNT, SHALL count COMMA and GOOD words; ERROR SHALL return to DOWN and clear the count; count reaching LOCKCNT SHALL enter UP on that clk edge.
REQ-009 In UP, SHALL follow a leaky-bucket rule:
- ERROR increments the bucket and clears the good-run counter.
- LEAKLEN consecutive non-ERROR words decrement the bucket (floor 0) and restart the run.
- Bucket reaching ERRMAX enters DOWN; bucket and run are cleared on entering DOWN or UP.
REQ-010 SHALL register xdata and xcomma with exactly 1 clk latency from rxdata.
REQ-011 Output per link SHALL be:
- UP and GOOD: xdata=rxdata, xcomma=0
- otherwise (UP and COMMA, UP and ERROR, HUNT, DOWN): xdata=16'h00BC, xcomma=1
REQ-012 linkup[k] SHALL be registered and equal 1 exactly while link k's FSM is UP; the word that completes the lock SHALL itself still be output as neutral.
REQ-013 errtot[k] SHALL increment on every ERROR word in any state, saturate at 16'hFFFF and never wrap.
REQ-014 errclr SHALL zero all errtot; errclr coinciding with an ERROR word SHALL leave errtot at 0 (clear wins).
REQ-015 Links SHALL be fully independent: simultaneous events on different links SHALL not interact.
REQ-016 A GOOD word with value 16'h0000 SHALL pass as data; only COMMA produces neutral output in UP.

Reset
REQ-017 On the clk edge with reset=1, SHALL set:
- xdata=48'h00BC_00BC_00BC, xcomma=3'b111, linkup=0, errtot=0
- all FSMs in DOWN, all counters and buckets 0
REQ-018 reset asserted mid-lock or in UP SHALL force DOWN on the next edge regardless of input.
REQ-019 The first cycle after reset deasserts SHALL classify normally.

Verification
REQ-020 SHALL cover these directed scenarios:
- Link0 sends one COMMA, then 64 GOOD words of 16'h0005 -> linkup[0]=1 after the 65th word's edge; the next GOOD 16'h0005 appears on xdata[15:0] one clk later with xcomma[0]=0.
- Link1 in HUNT with count 40 receives one ERROR -> DOWN, errtot[1]=1, xcomma[1]=1; lock then requires a COMMA plus 64 further words.
- Link2 in UP receives 4 ERROR words within 255 GOOD words -> linkup[2] falls after the 4th ERROR; with 256 GOOD words between each ERROR it stays UP.
- Link0 in UP receives 70000 ERROR words -> errtot[0]=16'hFFFF; errclr pulse -> 0 on next clk.
- All links in UP, reset pulsed for 1 clk -> next cycle linkup=0, xcomma=3'b111, xdata=48'h00BC_00BC_00BC.
- Link0 in UP receives charisk=2'b10 with data 16'hBC00 -> ERROR, neutral output, bucket=1.

Source files
------------

// File: rtl/xsum_rx.sv
// Three-link receive word cleaner: per-link DOWN/HUNT/UP lock FSM with a leaky error bucket,
// neutral-comma substitution on the registered output and saturating per-link error totals.
module xsum_rx #(
    parameter int LOCKCNT = 64,
    parameter int ERRMAX  = 4,
    parameter int LEAKLEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] rxdata,
    input  logic [5:0]  rxcharisk,
    input  logic [2:0]  rxerr,
    output logic [47:0] xdata,
    output logic [2:0]  xcomma,
    output logic [2:0]  linkup,
    output logic [47:0] errtot,
    input  logic        errclr
);

    localparam int CW = $clog2(LOCKCNT + 1);
    localparam int BW = $clog2(ERRMAX + 1);
    localparam int RW = $clog2(LEAKLEN + 1);
    localparam logic [15:0] NEUTRAL = 16'h00BC;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_HUNT = 2'd1,
        ST_UP   = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_link
            logic [15:0] word;
            logic [1:0]  isk;
            logic        is_comma;
            logic        is_good;
            logic        is_error;

            state_t      state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic [BW-1:0] bkt_q, bkt_d;
            logic [RW-1:0] run_q, run_d;
            logic [15:0] xdata_q, xdata_d;
            logic        xcomma_q, xcomma_d;
            logic [15:0] errtot_q, errtot_d;

            assign word     = rxdata[16*gi +: 16];
            assign isk      = rxcharisk[2*gi +: 2];
            assign is_comma = (isk == 2'b01) && (word == NEUTRAL) && !rxerr[gi];
            assign is_good  = (isk == 2'b00) && !rxerr[gi];
            assign is_error = !is_comma && !is_good;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q  <= ST_DOWN;
                    cnt_q    <= '0;
                    bkt_q    <= '0;
                    run_q    <= '0;
                    xdata_q  <= NEUTRAL;
                    xcomma_q <= 1'b1;
                    errtot_q <= '0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    bkt_q    <= bkt_d;
                    run_q    <= run_d;
                    xdata_q  <= xdata_d;
                    xcomma_q <= xcomma_d;
                    errtot_q <= errtot_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                bkt_d   = bkt_q;
                run_d   = run_q;
                case (state_q)
                    ST_DOWN: begin
                        cnt_d = '0;
                        bkt_d = '0;
                        run_d = '0;
                        if (is_comma) state_d = ST_HUNT;
                    end
                    ST_HUNT: begin
                        if (is_error) begin
                            state_d = ST_DOWN;
                            cnt_d   = '0;
                        end else if (cnt_q == CW'(LOCKCNT - 1)) begin
                            state_d = ST_UP;
                            cnt_d   = '0;
                            bkt_d   = '0;
                            run_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_UP: begin
                        if (is_error) begin
                            run_d = '0;
                            // Bucket would reach ERRMAX on this word: drop and clear.
                            if (bkt_q == BW'(ERRMAX - 1)) begin
                                state_d = ST_DOWN;
                                bkt_d   = '0;
                            end else begin
                                bkt_d = bkt_q + 1'b1;
                            end
                        end else if (run_q == RW'(LEAKLEN - 1)) begin
                            run_d = '0;
                            if (bkt_q != '0) bkt_d = bkt_q - 1'b1;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end
                    default: state_d = ST_DOWN;
                endcase
            end

            always_comb begin
                xdata_d  = NEUTRAL;
                xcomma_d = 1'b1;
                errtot_d = errtot_q;
                // Only data seen while already UP passes; the lock-completing word stays neutral.
                if ((state_q == ST_UP) && is_good) begin
                    xdata_d  = word;
                    xcomma_d = 1'b0;
                end
                if (errclr)
                    errtot_d = '0;
                else if (is_error && (errtot_q != 16'hFFFF))
                    errtot_d = errtot_q + 16'd1;
            end

            assign xdata[16*gi +: 16]  = xdata_q;
            assign xcomma[gi]          = xcomma_q;
            assign linkup[gi]          = (state_q == ST_UP);
            assign errtot[16*gi +: 16] = errtot_q;
        end
    endgenerate

endmodule

// File: tb/tb_xsum_rx.sv
// Directed bench for xsum_rx: a vector table for classification/error totals plus
// hand sequences for lock, unlock, leaky bucket, reset and saturation.
module tb_xsum_rx;

    logic        clk;
    logic        reset;
    logic [47:0] rxdata;
    logic [5:0]  rxcharisk;
    logic [2:0]  rxerr;
    logic [47:0] xdata;
    logic [2:0]  xcomma;
    logic [2:0]  linkup;
    logic [47:0] errtot;
    logic        errclr;

    localparam int T_GOOD  = 0;
    localparam int T_COMMA = 1;
    localparam int T_ERR   = 2;
    localparam logic [47:0] NEUT3 = 48'h00BC_00BC_00BC;

    int checks = 0;
    int errors = 0;

    xsum_rx dut (
        .clk       (clk),
        .reset     (reset),
        .rxdata    (rxdata),
        .rxcharisk (rxcharisk),
        .rxerr     (rxerr),
        .xdata     (xdata),
        .xcomma    (xcomma),
        .linkup    (linkup),
        .errtot    (errtot),
        .errclr    (errclr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        clr;
        logic [47:0] d;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [47:0] xd;
        logic [2:0]  xc;
        logic [2:0]  lu;
        logic [47:0] et;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_link(input int l, input int typ, input logic [15:0] d);
        case (typ)
            T_COMMA: begin
                rxdata[16*l +: 16]  = 16'h00BC;
                rxcharisk[2*l +: 2] = 2'b01;
                rxerr[l]            = 1'b0;
            end
            T_ERR: begin
                rxdata[16*l +: 16]  = d;
                rxcharisk[2*l +: 2] = 2'b00;
                rxerr[l]            = 1'b1;
            end
            default: begin
                rxdata[16*l +: 16]  = d;
                rxcharisk[2*l +: 2] = 2'b00;
                rxerr[l]            = 1'b0;
            end
        endcase
    endtask

    task automatic send(input int l, input int typ, input logic [15:0] d, input int n);
        set_link(l, typ, d);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        errclr    = 1'b0;
        rxdata    = '0;
        rxcharisk = '0;
        rxerr     = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic lock(input int l);
        send(l, T_COMMA, 16'h0000, 1);
        send(l, T_GOOD, 16'h0005, 64);
    endtask

    initial begin
        reset = 1'b0; errclr = 1'b0; rxdata = '0; rxcharisk = '0; rxerr = '0;

        // rst clr  rxdata  charisk  rxerr | xdata  xcomma linkup errtot
        tbl[0] = '{1'b1, 1'b0, 48'h0, 6'b00_00_00, 3'b000,
                   NEUT3, 3'b111, 3'b000, 48'h0};
        tbl[1] = '{1'b0, 1'b0, 48'h5555_1234_00BC, 6'b00_00_01, 3'b100,
                   NEUT3, 3'b111, 3'b000, 48'h0001_0000_0000};
        tbl[2] = '{1'b0, 1'b0, 48'h00BC_0000_BC00, 6'b01_11_10, 3'b100,
                   NEUT3, 3'b111, 3'b000, 48'h0002_0001_0001};
        tbl[3] = '{1'b0, 1'b1, 48'h0, 6'b00_00_00, 3'b001,
                   NEUT3, 3'b111, 3'b000, 48'h0};
        tbl[4] = '{1'b0, 1'b0, 48'h00BC_00BC_00BD, 6'b10_00_01, 3'b000,
                   NEUT3, 3'b111, 3'b000, 48'h0001_0000_0001};
        tbl[5] = '{1'b0, 1'b0, 48'h0, 6'b00_00_00, 3'b000,
                   NEUT3, 3'b111, 3'b000, 48'h0001_0000_0001};

        for (int i = 0; i < 6; i++) begin
            reset = tbl[i].rst; errclr = tbl[i].clr;
            rxdata = tbl[i].d; rxcharisk = tbl[i].k; rxerr = tbl[i].e;
            step();
            $display("vec %0d: rxdata=%h k=%b e=%b -> xdata=%h xcomma=%b linkup=%b errtot=%h",
                     i, tbl[i].d, tbl[i].k, tbl[i].e, xdata, xcomma, linkup, errtot);
            chk($sformatf("vec%0d xdata", i), xdata, tbl[i].xd);
            chk($sformatf("vec%0d xcomma", i), 48'(xcomma), 48'(tbl[i].xc));
            chk($sformatf("vec%0d linkup", i), 48'(linkup), 48'(tbl[i].lu));
            chk($sformatf("vec%0d errtot", i), errtot, tbl[i].et);
        end
        reset = 1'b0; errclr = 1'b0;

        // Link0 lock: comma + 64 good words, lock word still neutral
        do_reset();
        send(0, T_COMMA, 16'h0000, 1);
        send(0, T_GOOD, 16'h0005, 63);
        chk("A linkup before 64th", 48'(linkup[0]), 48'd0);
        send(0, T_GOOD, 16'h0005, 1);
        chk("A linkup after lock", 48'(linkup[0]), 48'd1);
        chk("A lock word neutral", 48'(xcomma[0]), 48'd1);
        chk("A lock word data", 48'(xdata[15:0]), 48'h00BC);
        send(0, T_GOOD, 16'h0005, 1);
        chk("A first data", 48'(xdata[15:0]), 48'h0005);
        chk("A first data xcomma", 48'(xcomma[0]), 48'd0);
        send(0, T_GOOD, 16'h0000, 1);
        chk("A zero data", 48'(xdata[15:0]), 48'h0000);
        chk("A zero xcomma", 48'(xcomma[0]), 48'd0);
        send(0, T_COMMA, 16'h0000, 1);
        chk("A comma in UP xcomma", 48'(xcomma[0]), 48'd1);
        chk("A comma in UP linkup", 48'(linkup[0]), 48'd1);
        rxdata[15:0] = 16'hBC00; rxcharisk[1:0] = 2'b10; rxerr[0] = 1'b0;
        step();
        chk("A K-high err xcomma", 48'(xcomma[0]), 48'd1);
        chk("A K-high err xdata", 48'(xdata[15:0]), 48'h00BC);
        chk("A K-high err errtot", 48'(errtot[15:0]), 48'd1);
        chk("A K-high err linkup", 48'(linkup[0]), 48'd1);
        step();
        step();
        chk("A bucket 3 still up", 48'(linkup[0]), 48'd1);
        step();
        chk("A bucket 4 down", 48'(linkup[0]), 48'd0);
        chk("A errtot 4", 48'(errtot[15:0]), 48'd4);

        // Link1: error in HUNT at count 40 returns to DOWN and clears the count
        do_reset();
        send(1, T_COMMA, 16'h0000, 1);
        send(1, T_GOOD, 16'h1111, 40);
        send(1, T_ERR, 16'h1111, 1);
        chk("B err linkup", 48'(linkup[1]), 48'd0);
        chk("B err errtot", 48'(errtot[31:16]), 48'd1);
        chk("B err xcomma", 48'(xcomma[1]), 48'd1);
        send(1, T_GOOD, 16'h1111, 30);
        chk("B DOWN holds on good", 48'(linkup[1]), 48'd0);
        send(1, T_COMMA, 16'h0000, 1);
        send(1, T_GOOD, 16'h1111, 63);
        chk("B relock 63", 48'(linkup[1]), 48'd0);
        send(1, T_GOOD, 16'h1111, 1);
        chk("B relock 64", 48'(linkup[1]), 48'd1);
        chk("B link0 untouched", 48'(errtot[15:0]), 48'd0);

        // Link2: 4 errors within 255 goods drop; errors spaced by 256 goods leak away
        do_reset();
        lock(2);
        chk("C locked", 48'(linkup), 48'b100);
        for (int e = 0; e < 4; e++) begin
            send(2, T_ERR, 16'h2222, 1);
            chk($sformatf("C dense err %0d", e), 48'(linkup[2]), (e < 3) ? 48'd1 : 48'd0);
            if (e < 3) send(2, T_GOOD, 16'h2222, 85);
        end
        lock(2);
        for (int e = 0; e < 5; e++) begin
            send(2, T_ERR, 16'h2222, 1);
            chk($sformatf("C sparse err %0d", e), 48'(linkup[2]), 48'd1);
            send(2, T_GOOD, 16'h2222, 256);
        end
        chk("C sparse errtot", 48'(errtot[47:32]), 48'd9);

        // All links UP, then reset pulse; mid-lock reset; first cycle after reset classifies
        do_reset();
        for (int l = 0; l < 3; l++) set_link(l, T_COMMA, 16'h0000);
        step();
        for (int l = 0; l < 3; l++) set_link(l, T_GOOD, 16'h0005);
        repeat (64) step();
        chk("D all up", 48'(linkup), 48'b111);
        step();
        chk("D all data", xdata, 48'h0005_0005_0005);
        chk("D all xcomma", 48'(xcomma), 48'b000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("D reset linkup", 48'(linkup), 48'b000);
        chk("D reset xcomma", 48'(xcomma), 48'b111);
        chk("D reset xdata", xdata, NEUT3);
        chk("D reset errtot", errtot, 48'h0);
        send(0, T_COMMA, 16'h0000, 1);
        send(0, T_GOOD, 16'h0005, 30);
        reset = 1'b1;
        send(0, T_COMMA, 16'h0000, 1);
        reset = 1'b0;
        send(0, T_GOOD, 16'h0005, 64);
        chk("D mid-lock reset to DOWN", 48'(linkup[0]), 48'd0);
        lock(0);
        chk("D lock after reset", 48'(linkup[0]), 48'd1);

        // Saturation of all error totals, then clear
        do_reset();
        lock(0);
        rxerr = 3'b111;
        repeat (66000) step();
        chk("E saturated", errtot, 48'hFFFF_FFFF_FFFF);
        chk("E dropped", 48'(linkup), 48'b000);
        errclr = 1'b1;
        step();
        errclr = 1'b0;
        chk("E clear with error", errtot, 48'h0);
        rxerr = 3'b001;
        step();
        rxerr = 3'b000;
        chk("E count after clear", errtot, 48'h0000_0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
